// File: rtl/cla_pipe_adder_if.sv
// Valid/ready stream bundle for cla_pipe_adder.
// The ovf signal exists only when CLA_OVF_EN is defined.
interface cla_pipe_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/cla_pipe_adder.sv
// Carry-pipelined CLA adder: one GROUP-bit lookahead group is resolved per stage.
// Define CLA_OVF_EN to add the registered signed-overflow output.
module cla_group #(parameter int GROUP = 4) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co
);
    logic [GROUP-1:0] g, p;
    logic [GROUP:0]   c;

    always_comb begin
        g    = a & b;
        p    = a | b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign s  = a ^ b ^ c[GROUP-1:0];
    assign co = c[GROUP];
endmodule

module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    cla_pipe_adder_if.slave  bus
);
    localparam int STAGES = WIDTH / GROUP;

    if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a positive multiple of GROUP");
    end

    // *_i: stage inputs (ports for stage 0, previous stage regs otherwise); *_r: stage regs
    logic [STAGES-1:0][WIDTH-1:0] a_i, b_i, s_i, a_r, b_r, s_r;
    logic [STAGES-1:0]            c_i, c_r, gc;
    logic [STAGES-1:0][GROUP-1:0] gs;
    logic [STAGES:1]              vld_pipe;
    logic                         adv;

    assign adv = !vld_pipe[STAGES] || bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_i[k] = bus.a;
            assign b_i[k] = bus.b;
            assign s_i[k] = '0;
            assign c_i[k] = bus.cin;
        end else begin : g_body
            assign a_i[k] = a_r[k-1];
            assign b_i[k] = b_r[k-1];
            assign s_i[k] = s_r[k-1];
            assign c_i[k] = c_r[k-1];
        end

        cla_group #(.GROUP(GROUP)) u_grp (
            .a  (a_i[k][k*GROUP +: GROUP]),
            .b  (b_i[k][k*GROUP +: GROUP]),
            .ci (c_i[k]),
            .s  (gs[k]),
            .co (gc[k])
        );
    end

    // Whole pipe moves together; a stalled output freezes every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            a_r      <= '0;
            b_r      <= '0;
            s_r      <= '0;
            c_r      <= '0;
        end else if (adv) begin
            vld_pipe[1] <= bus.in_valid;
            for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]                   <= a_i[k];
                b_r[k]                   <= b_i[k];
                s_r[k]                   <= s_i[k];
                s_r[k][k*GROUP +: GROUP] <= gs[k];
                c_r[k]                   <= gc[k];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.sum       = s_r[STAGES-1];
    assign bus.cout      = c_r[STAGES-1];

`ifdef CLA_OVF_EN
    logic ovf_r;
    logic c_msb;

    // Carry into the MSB recovered from the MSB sum bit: c = s ^ a ^ b.
    assign c_msb = gs[STAGES-1][GROUP-1] ^ a_i[STAGES-1][WIDTH-1] ^ b_i[STAGES-1][WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      ovf_r <= 1'b0;
        else if (adv) ovf_r <= c_msb ^ gc[STAGES-1];
    end

    assign bus.ovf = ovf_r;
`endif
endmodule
